// File: rtl/acc_pkg.sv
// Shared encodings for the accumulator bank: load source select and dump buffer state.
package acc_pkg;

  localparam logic [1:0] SRC_IMM = 2'b00;
  localparam logic [1:0] SRC_REG = 2'b01;
  localparam logic [1:0] SRC_ALU = 2'b10;
  localparam logic [1:0] SRC_CLR = 2'b11;

  typedef enum logic {
    DUMP_EMPTY = 1'b0,
    DUMP_FULL  = 1'b1
  } dump_state_e;

endpackage

// File: rtl/acc_dump_buf.sv
// One-entry valid/ready buffer carrying accumulator dumps to the register path.
module acc_dump_buf
  import acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             ready,
  input  logic [WIDTH-1:0] din,
  output logic             ack,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  dump_state_e state, state_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DUMP_EMPTY;
      dout  <= '0;
    end else begin
      state <= state_nxt;
      if (ack) dout <= din;
    end
  end

  // A full entry can be refilled in the same cycle it drains, giving one dump per cycle.
  always_comb begin
    state_nxt = state;
    ack       = req & ((state == DUMP_EMPTY) | ready);
    case (state)
      DUMP_EMPTY: if (ack) state_nxt = DUMP_FULL;
      DUMP_FULL:  if (!ack && ready) state_nxt = DUMP_EMPTY;
      default:    state_nxt = DUMP_EMPTY;
    endcase
  end

  assign valid = (state == DUMP_FULL);

endmodule

// File: rtl/acc_bank.sv
// Bank of NUM_ACC accumulators: one write port, a combinational ALU read port,
// and a buffered dump port toward the register file.
module acc_bank
  import acc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_ACC = 4,
  parameter int SEL_W   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [SEL_W-1:0] load_sel,
  input  logic [1:0]       src_sel,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [WIDTH-1:0] in_reg,
  input  logic [WIDTH-1:0] in_alu,
  input  logic [SEL_W-1:0] alu_sel,
  output logic [WIDTH-1:0] out_alu,
  output logic             flag_zero,
  output logic             flag_neg,
  input  logic             dump_req,
  input  logic [SEL_W-1:0] dump_sel,
  output logic             dump_ack,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [WIDTH-1:0] dump_data
);

  logic [NUM_ACC-1:0][WIDTH-1:0] acc;
  logic [WIDTH-1:0]              wr_val;
  logic [WIDTH-1:0]              dump_src;

  always_comb begin
    wr_val = '0;
    case (src_sel)
      SRC_IMM: wr_val = in_imm;
      SRC_REG: wr_val = in_reg;
      SRC_ALU: wr_val = in_alu;
      SRC_CLR: wr_val = '0;
      default: wr_val = '0;
    endcase
  end

  // Indices past NUM_ACC match no entry, so such writes fall away.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (load_en) begin
      for (int i = 0; i < NUM_ACC; i++)
        if (load_sel == SEL_W'(i)) acc[i] <= wr_val;
    end
  end

  // Out-of-range selects read as zero on both read ports.
  always_comb begin
    out_alu  = '0;
    dump_src = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (alu_sel == SEL_W'(i))  out_alu  = acc[i];
      if (dump_sel == SEL_W'(i)) dump_src = acc[i];
    end
  end

  assign flag_zero = (out_alu == '0);
  assign flag_neg  = out_alu[WIDTH-1];

  acc_dump_buf #(.WIDTH(WIDTH)) u_dump (
    .clk   (clk),
    .reset (reset),
    .req   (dump_req),
    .ready (dump_ready),
    .din   (dump_src),
    .ack   (dump_ack),
    .valid (dump_valid),
    .dout  (dump_data)
  );

endmodule

// File: tb/tb_acc_bank.sv
// Bench for acc_bank: directed plan steps plus random traffic, checked against
// an array/buffer reference model for a full (4) and a partial (3) bank.
module tb_acc_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, load_en, dump_req, dump_ready;
  logic [1:0] load_sel, src_sel, alu_sel, dump_sel;
  logic [7:0] in_imm, in_reg, in_alu;

  logic [7:0] o_alu[2];
  logic [7:0] o_data[2];
  logic       o_zero[2], o_neg[2], o_ack[2], o_valid[2];

  acc_bank #(.WIDTH(8), .NUM_ACC(4), .SEL_W(2)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_sel(load_sel),
    .src_sel(src_sel), .in_imm(in_imm), .in_reg(in_reg), .in_alu(in_alu),
    .alu_sel(alu_sel), .out_alu(o_alu[0]), .flag_zero(o_zero[0]), .flag_neg(o_neg[0]),
    .dump_req(dump_req), .dump_sel(dump_sel), .dump_ack(o_ack[0]),
    .dump_valid(o_valid[0]), .dump_ready(dump_ready), .dump_data(o_data[0])
  );

  acc_bank #(.WIDTH(8), .NUM_ACC(3), .SEL_W(2)) dut3 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_sel(load_sel),
    .src_sel(src_sel), .in_imm(in_imm), .in_reg(in_reg), .in_alu(in_alu),
    .alu_sel(alu_sel), .out_alu(o_alu[1]), .flag_zero(o_zero[1]), .flag_neg(o_neg[1]),
    .dump_req(dump_req), .dump_sel(dump_sel), .dump_ack(o_ack[1]),
    .dump_valid(o_valid[1]), .dump_ready(dump_ready), .dump_data(o_data[1])
  );

  int         n_acc[2] = '{4, 3};
  logic [7:0] m_acc[2][4];
  logic       m_valid[2];
  logic [7:0] m_data[2];
  int         total = 0;
  int         fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_rd(input int d, input logic [1:0] s);
    return (int'(s) < n_acc[d]) ? m_acc[d][s] : 8'h00;
  endfunction

  function automatic logic [7:0] m_src();
    case (src_sel)
      2'd0:    return in_imm;
      2'd1:    return in_reg;
      2'd2:    return in_alu;
      default: return 8'h00;
    endcase
  endfunction

  task automatic idle();
    reset = 0; load_en = 0; load_sel = 0; src_sel = 0;
    in_imm = 0; in_reg = 0; in_alu = 0;
    dump_req = 0; dump_sel = 0; dump_ready = 0;
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      logic [7:0] e;
      e = m_rd(d, alu_sel);
      chk($sformatf("out_alu[%0d]", d), o_alu[d], e);
      chk($sformatf("flag_zero[%0d]", d), o_zero[d], e == 8'h00);
      chk($sformatf("flag_neg[%0d]", d), o_neg[d], e[7]);
      chk($sformatf("dump_ack[%0d]", d), o_ack[d], dump_req & (!m_valid[d] | dump_ready));
      chk($sformatf("dump_valid[%0d]", d), o_valid[d], m_valid[d]);
      chk($sformatf("dump_data[%0d]", d), o_data[d], m_data[d]);
    end
  endtask

  // Check the current cycle, then advance model and DUT over one edge.
  task automatic tick();
    logic [7:0] na[2][4];
    logic       nv[2];
    logic [7:0] nd[2];
    #1;
    check_outputs();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) na[d][i] = m_acc[d][i];
      nv[d] = m_valid[d];
      nd[d] = m_data[d];
      if (reset) begin
        for (int i = 0; i < 4; i++) na[d][i] = 8'h00;
        nv[d] = 1'b0;
        nd[d] = 8'h00;
      end else begin
        if (dump_req && (!m_valid[d] || dump_ready)) begin
          nd[d] = m_rd(d, dump_sel);
          nv[d] = 1'b1;
        end else if (dump_ready) begin
          nv[d] = 1'b0;
        end
        if (load_en && int'(load_sel) < n_acc[d]) na[d][load_sel] = m_src();
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) m_acc[d][i] = na[d][i];
      m_valid[d] = nv[d];
      m_data[d]  = nd[d];
    end
    #1;
  endtask

  task automatic load(input logic [1:0] sel, input logic [1:0] src, input logic [7:0] v);
    load_en = 1; load_sel = sel; src_sel = src;
    in_imm = v; in_reg = v; in_alu = v;
  endtask

  initial begin
    idle();
    alu_sel = 0;
    reset = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) m_acc[d][i] = 8'h00;
      m_valid[d] = 1'b0;
      m_data[d]  = 8'h00;
    end
    reset = 0;
    #1;
    chk("reset_valid", o_valid[0], 1'b0);
    chk("reset_data", o_data[0], 8'h00);

    // ALU-sourced load is visible the following cycle only on acc2.
    load(2'd2, 2'b10, 8'h5A); tick();
    idle(); alu_sel = 2; #1;
    chk("t1_alu", o_alu[0], 8'h5A);
    chk("t1_zero", o_zero[0], 1'b0);
    tick();
    alu_sel = 1; #1; chk("t1_acc1", o_alu[0], 8'h00);
    alu_sel = 3; #1; chk("t1_acc3", o_alu[0], 8'h00);

    // Immediate then clear on acc1.
    load(2'd1, 2'b00, 8'h80); tick();
    idle(); alu_sel = 1; #1;
    chk("t2_alu", o_alu[0], 8'h80);
    chk("t2_neg", o_neg[0], 1'b1);
    load(2'd1, 2'b11, 8'h7E); tick();
    idle(); #1;
    chk("t2_clr", o_alu[0], 8'h00);
    chk("t2_zero", o_zero[0], 1'b1);

    // Stalled dump of acc3.
    load(2'd3, 2'b01, 8'h33); tick();
    idle(); dump_req = 1; dump_sel = 3; #1;
    chk("t3_ack0", o_ack[0], 1'b1);
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("t3_valid", o_valid[0], 1'b1);
      chk("t3_data", o_data[0], 8'h33);
      chk("t3_noack", o_ack[0], 1'b0);
      tick();
    end
    dump_ready = 1; #1;
    chk("t3_ack1", o_ack[0], 1'b1);
    tick();
    idle(); dump_ready = 1; tick();

    // Back-to-back dumps of 1,2,3,4.
    idle();
    for (int i = 0; i < 4; i++) begin load(2'(i), 2'b00, 8'(i + 1)); tick(); end
    idle(); dump_ready = 1; dump_req = 1;
    for (int i = 0; i < 4; i++) begin
      dump_sel = 2'(i);
      tick();
      chk("t4_data", o_data[0], 8'(i + 1));
      chk("t4_valid", o_valid[0], 1'b1);
    end
    idle(); dump_ready = 1; tick();

    // Simultaneous load and dump of acc0 captures the old value.
    idle(); load(2'd0, 2'b00, 8'h11); tick();
    load(2'd0, 2'b00, 8'hFF); dump_req = 1; dump_sel = 0; dump_ready = 1; tick();
    idle(); alu_sel = 0; #1;
    chk("t5_data", o_data[0], 8'h11);
    chk("t5_acc0", o_alu[0], 8'hFF);

    // Reset while a dump is pending.
    load(2'd2, 2'b00, 8'h77); dump_req = 1; dump_sel = 2; tick();
    idle(); tick();
    reset = 1; tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      alu_sel = 2'(i); #1;
      chk("t6_acc", o_alu[0], 8'h00);
    end
    chk("t6_valid", o_valid[0], 1'b0);
    chk("t6_data", o_data[0], 8'h00);

    // Random traffic including out-of-range indices on the 3-entry bank.
    for (int c = 0; c < 400; c++) begin
      reset      = ($urandom_range(0, 39) == 0);
      load_en    = $urandom_range(0, 1);
      load_sel   = 2'($urandom_range(0, 3));
      src_sel    = 2'($urandom_range(0, 3));
      in_imm     = 8'($urandom);
      in_reg     = 8'($urandom);
      in_alu     = 8'($urandom);
      alu_sel    = 2'($urandom_range(0, 3));
      dump_req   = $urandom_range(0, 1);
      dump_sel   = 2'($urandom_range(0, 3));
      dump_ready = $urandom_range(0, 1);
      tick();
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
